// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter:
// FSM encoding, requester IDs, default depth and the address check.
package dm_port_arbiter_pkg;

    localparam int DEPTH_WORDS_DEF = 3072;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    // An access is illegal if it is not word aligned or if its word index
    // falls past the end of the memory.
    function automatic logic addr_err(input logic [31:0] addr, input int depth);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= $unsigned(depth));
    endfunction

endpackage

// File: rtl/dm_rr_pick2.sv
// Combinational two-way round-robin picker. When both requesters are
// active the one that did not win last time is chosen.
module dm_rr_pick2 (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic [1:0] gnt
);

    // One-hot (or zero) grant; ties go to the requester opposite rr_last.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | rr_last);
        gnt[1] = req[1] & (~req[0] | ~rr_last);
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory.
// A grant in IDLE latches the winner's command, the memory command is
// presented from registers during ACCESS, and the owner receives a
// one-cycle response pulse on the cycle after ACCESS.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int IDX_W       = 12
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [31:0]      m0_rdata,
    output logic             m0_err,

    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [31:0]      m1_rdata,
    output logic             m1_err,

    output logic             mem_en,
    output logic [IDX_W-1:0] mem_addr,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_rr_last;
    logic              r_owner;
    logic              r_we;
    logic              r_err;

    logic              r_mem_en;
    logic [IDX_W-1:0]  r_mem_addr;
    logic [31:0]       r_mem_wd;

    logic              r_m0_rvalid;
    logic [31:0]       r_m0_rdata;
    logic              r_m0_err;
    logic              r_m1_rvalid;
    logic [31:0]       r_m1_rdata;
    logic              r_m1_err;

    logic [1:0]        w_req;
    logic [1:0]        w_pick;
    logic [1:0]        w_gnt;
    logic              w_take;
    logic              w_owner;
    logic              w_sel_we;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_sel_err;
    logic              w_rd_ok;

    assign w_req = {m1_req, m0_req};

    dm_rr_pick2 u_pick (
        .req     (w_req),
        .rr_last (r_rr_last),
        .gnt     (w_pick)
    );

    // Next-state and grant decode; grants are only offered in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 2'b00;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_gnt       = w_pick;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_take  = w_gnt[0] | w_gnt[1];
    assign w_owner = w_gnt[1] ? REQ_AUX : REQ_CPU;

    // Mux the winning requester's command fields.
    always_comb begin
        w_sel_we    = m0_we;
        w_sel_addr  = m0_addr;
        w_sel_wdata = m0_wdata;
        if (w_owner == REQ_AUX) begin
            w_sel_we    = m1_we;
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
        end
        w_sel_err = addr_err(w_sel_addr, DEPTH_WORDS);
    end

    assign m0_gnt = w_gnt[0];
    assign m1_gnt = w_gnt[1];

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the granted command and present the memory command during ACCESS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_last  <= 1'b1;
            r_owner    <= REQ_CPU;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_wd   <= '0;
        end else if (w_take) begin
            r_rr_last  <= w_owner;
            r_owner    <= w_owner;
            r_we       <= w_sel_we;
            r_err      <= w_sel_err;
            r_mem_en   <= w_sel_we & ~w_sel_err;
            r_mem_addr <= w_sel_addr[IDX_W+1:2];
            r_mem_wd   <= w_sel_wdata;
        end else begin
            r_mem_en   <= 1'b0;
        end
    end

    assign w_rd_ok = ~r_we & ~r_err;

    // Issue the owner's response pulse on the ACCESS->IDLE edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m0_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m0_err    <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m1_rdata  <= '0;
            r_m1_err    <= 1'b0;
        end else begin
            r_m0_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m0_err    <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m1_rdata  <= '0;
            r_m1_err    <= 1'b0;
            if (r_state == ACCESS) begin
                if (r_owner == REQ_CPU) begin
                    r_m0_rvalid <= 1'b1;
                    r_m0_rdata  <= w_rd_ok ? mem_rd : 32'h0;
                    r_m0_err    <= r_err;
                end else begin
                    r_m1_rvalid <= 1'b1;
                    r_m1_rdata  <= w_rd_ok ? mem_rd : 32'h0;
                    r_m1_err    <= r_err;
                end
            end
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_addr  = r_mem_addr;
    assign mem_wd    = r_mem_wd;
    assign m0_rvalid = r_m0_rvalid;
    assign m0_rdata  = r_m0_rdata;
    assign m0_err    = r_m0_err;
    assign m1_rvalid = r_m1_rvalid;
    assign m1_rdata  = r_m1_rdata;
    assign m1_err    = r_m1_err;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small behavioural data memory.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int n_chk  = 0;
    int n_fail = 0;

    dm_port_arbiter #(.DEPTH_WORDS(3072), .IDX_W(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory: synchronous write, combinational read.
    logic [31:0] mem [0:3071];
    always @(posedge clk) begin
        if (mem_en && mem_addr < 12'd3072) mem[mem_addr] <= mem_wd;
    end
    assign mem_rd = (mem_addr < 12'd3072) ? mem[mem_addr] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One isolated transaction; starts and ends on a negedge with the DUT in IDLE.
    task automatic xfer(input logic who, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_en, input logic exp_err,
                        input logic [31:0] exp_rdata, input string tag);
        if (who == 1'b0) begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
        #1;
        chk({tag, ".gnt"}, {30'd0, m1_gnt, m0_gnt}, who ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        chk({tag, ".gnt_acc"}, {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk({tag, ".mem_en"}, {31'd0, mem_en}, {31'd0, exp_en});
        chk({tag, ".mem_addr"}, {20'd0, mem_addr}, {20'd0, addr[13:2]});
        if (exp_en) chk({tag, ".mem_wd"}, mem_wd, wdata);
        @(negedge clk);
        if (who == 1'b0) begin
            chk({tag, ".rvalid"}, {31'd0, m0_rvalid}, 32'd1);
            chk({tag, ".other_rvalid"}, {31'd0, m1_rvalid}, 32'd0);
            chk({tag, ".err"}, {31'd0, m0_err}, {31'd0, exp_err});
            chk({tag, ".rdata"}, m0_rdata, exp_rdata);
        end else begin
            chk({tag, ".rvalid"}, {31'd0, m1_rvalid}, 32'd1);
            chk({tag, ".other_rvalid"}, {31'd0, m0_rvalid}, 32'd0);
            chk({tag, ".err"}, {31'd0, m1_err}, {31'd0, exp_err});
            chk({tag, ".rdata"}, m1_rdata, exp_rdata);
        end
    endtask

    initial begin
        reset = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        @(negedge clk); @(negedge clk);

        chk("rst.mem_en",    {31'd0, mem_en}, 32'd0);
        chk("rst.mem_addr",  {20'd0, mem_addr}, 32'd0);
        chk("rst.mem_wd",    mem_wd, 32'd0);
        chk("rst.m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("rst.m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        chk("rst.m0_rdata",  m0_rdata, 32'd0);
        chk("rst.m1_rdata",  m1_rdata, 32'd0);
        chk("rst.m0_err",    {31'd0, m0_err}, 32'd0);
        chk("rst.m1_err",    {31'd0, m1_err}, 32'd0);
        chk("rst.gnt",       {30'd0, m1_gnt, m0_gnt}, 32'd0);

        reset = 1'b1;
        @(negedge clk);

        xfer(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, "wr10");
        xfer(1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF, "rd10");

        xfer(1'b0, 1'b1, 32'h0000_0012, 32'h5555_5555, 1'b0, 1'b1, 32'h0, "mis_wr");
        xfer(1'b0, 1'b1, 32'h0000_3000, 32'h6666_6666, 1'b0, 1'b1, 32'h0, "oor_wr");
        xfer(1'b0, 1'b0, 32'h0000_0013, 32'h0,         1'b0, 1'b1, 32'h0, "mis_rd");
        xfer(1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF, "rd10_again");

        xfer(1'b0, 1'b1, 32'h0000_2FFC, 32'hA5A5_5A5A, 1'b1, 1'b0, 32'h0, "wr_top");
        xfer(1'b0, 1'b0, 32'h0000_2FFC, 32'h0,         1'b0, 1'b0, 32'hA5A5_5A5A, "rd_top");

        xfer(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1, 1'b0, 32'h0, "wr20");

        // Round robin with both requesters held right after a reset.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i % 2 == 1)
                chk($sformatf("rr.gnt%0d", i), {30'd0, m1_gnt, m0_gnt}, 32'd0);
            else if ((i / 2) % 2 == 0)
                chk($sformatf("rr.gnt%0d", i), {30'd0, m1_gnt, m0_gnt}, 32'd1);
            else
                chk($sformatf("rr.gnt%0d", i), {30'd0, m1_gnt, m0_gnt}, 32'd2);
            if (i == 2) begin
                chk("rr.m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
                chk("rr.m0_rdata",  m0_rdata, 32'hDEAD_BEEF);
            end
            if (i == 4) begin
                chk("rr.m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
                chk("rr.m1_rdata",  m1_rdata, 32'h1234_5678);
            end
            @(negedge clk);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset asserted in the middle of a write's ACCESS cycle.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'hBAD0_BAD0;
        #1;
        chk("rstacc.gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        @(posedge clk); #1;
        m0_req = 1'b0;
        #1;
        chk("rstacc.en_before", {31'd0, mem_en}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rstacc.en_dropped", {31'd0, mem_en}, 32'd0);
        @(posedge clk); #1;
        chk("rstacc.no_rvalid", {31'd0, m0_rvalid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Tie after reset: m0 must win; m1 follows while m0's response is out.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10;
        #1;
        chk("tie.gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        @(posedge clk); #1;
        m0_req = 1'b0;
        @(negedge clk);
        chk("tie.mem_en",   {31'd0, mem_en}, 32'd0);
        chk("tie.mem_addr", {20'd0, mem_addr}, 32'd8);
        @(negedge clk);
        chk("tie.m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
        chk("tie.m0_rdata",  m0_rdata, 32'h1234_5678);
        chk("tie.m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        chk("tie.gnt_m1",    {30'd0, m1_gnt, m0_gnt}, 32'd2);
        @(posedge clk); #1;
        m1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("tie.m1_rvalid2", {31'd0, m1_rvalid}, 32'd1);
        chk("tie.m1_rdata",   m1_rdata, 32'hDEAD_BEEF);
        chk("tie.m1_err",     {31'd0, m1_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port, word-addressed data memory (3072 x 32-bit words, byte address bits [13:2]).
- Requester 0 is the CPU MEM stage; requester 1 is a secondary master (debug loader or DMA).
- Serialises accesses and issues registered memory commands.
- Returns read data or an error through a per-requester response pulse.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words in the data memory; valid word index is 0..DEPTH_WORDS-1.
- IDX_W, 12, width of the memory word index, equal to ceil(log2(DEPTH_WORDS)).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- m0_req  in  1  requester 0 command valid; held with its fields stable until m0_gnt.
- m0_we  in  1  requester 0: 1 = write, 0 = read.
- m0_addr  in  32  requester 0 byte address.
- m0_wdata  in  32  requester 0 write data.
- m0_gnt  out  1  requester 0 command accepted this cycle.
- m0_rvalid  out  1  one-cycle response pulse for requester 0.
- m0_rdata  out  32  read data; 0 for writes or errors.
- m0_err  out  1  qualifies m0_rvalid: misaligned or out-of-range access.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as m0, for requester 1.
- mem_en  out  1  memory write enable (registered).
- mem_addr  out  IDX_W  memory word index (registered).
- mem_wd  out  32  memory write data (registered).
- mem_rd  in  32  memory combinational read data for mem_addr.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_last=1, so requester 0 wins the first tie.
  - All registered outputs cleared: mem_en, mem_addr, mem_wd, mX_rvalid, mX_rdata, mX_err are 0.
  - Any in-flight command is dropped; no response is produced for it.
- FSM has two states, IDLE and ACCESS.
  - IDLE: if any req is high, grant exactly one; mX_gnt is combinational and high only in IDLE. Latch we/addr/wdata/owner, then go to ACCESS. With no request, stay in IDLE.
  - ACCESS: mem_addr = latched addr[13:2]; mem_en = latched we and not err; mem_wd = latched wdata. Always return to IDLE next cycle; gnt is 0 throughout.
- Arbitration:
  - Only one requester active: it wins.
  - Both active: the requester not equal to rr_last wins.
  - rr_last updates to the owner on every grant.
- Error check, done at grant time:
  - err = (addr[1:0] != 0) or (addr[31:2] >= DEPTH_WORDS).
  - On error, mem_en stays 0 in ACCESS.
- Response:
  - On the ACCESS->IDLE edge, the owner's rvalid is set for exactly one cycle.
  - rdata = mem_rd sampled at the end of ACCESS for a non-error read; otherwise 0.
  - err = latched err.
  - The non-owner's rvalid stays 0.
- Latency: grant at cycle T, memory command at T+1, rvalid at T+2.
  - A new grant may occur at T+2 while the previous rvalid is high.
  - Peak throughput is one access per 2 cycles.
- A read following a write to the same address returns the new data, because the write commits at the end of ACCESS, before the next ACCESS.
- A requester dropping req before gnt is legal: the command is simply not taken. Fields changing while req is high and gnt is low are unsupported.
- Reset asserted during ACCESS: mem_en drops asynchronously, so no write occurs, and no rvalid is produced.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=1'b0, ACCESS=1'b1.
  - DEPTH_WORDS default.
  - Requester ID constants: REQ_CPU=0, REQ_AUX=1.
- One natural sub-module: dm_rr_pick2. It is a combinational 2-way round-robin picker with inputs req[1:0] and rr_last, and outputs gnt[1:0] (one-hot or zero).

Test Plan:
- Reset, then m0 write addr=0x0000_0010, wdata=0xDEAD_BEEF → m0_gnt at T, mem_en=1 and mem_addr=4 at T+1, m0_rvalid=1 and m0_err=0 at T+2.
- Then m1 read addr=0x10 → m1_rvalid at T+2 with m1_rdata=0xDEAD_BEEF, m1_err=0, m0_rvalid=0.
- Both req held continuously after reset → grants alternate m0, m1, m0, m1 every 2 cycles; no requester is granted twice in a row.
- m0 write addr=0x0000_0012 (misaligned) and addr=0x0000_3000 (word 3072) → mem_en stays 0; m0_rvalid with m0_err=1 and m0_rdata=0 for each.
- m0 write addr=0x2FFC (word 3071), then read it back → no error; data returned intact.
- Pull reset low during ACCESS of a write to 0x20 → no mem_en pulse, no rvalid. After release, a read of 0x20 returns the prior contents, and m0 wins the first tie.
